// File: rtl/reg_read_stage_pkg.sv
// rtl/reg_read_stage_pkg.sv - shared defaults and register-index type for the read stage
package reg_read_stage_pkg;
    localparam int DATA_W_DEF   = 64;
    localparam int NREG_DEF     = 32;
    localparam int ZERO_REG_DEF = 31;
    localparam int IDX_W        = 5;
    localparam int OP_W         = 11;

    typedef logic [IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits for in-flight destination writes
module rf_scoreboard
    import reg_read_stage_pkg::*;
#(
    parameter int NREG = NREG_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_i,
    input  reg_idx_t        set_idx_i,
    input  logic            clr_i,
    input  reg_idx_t        clr_idx_i,
    input  logic            fclr_i,
    input  reg_idx_t        fclr_idx_i,
    output logic [NREG-1:0] busy_o
);
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Clears are applied first so a same-cycle set on the same index wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_i)  busy_d[clr_idx_i]  = 1'b0;
        if (fclr_i) busy_d[fclr_idx_i] = 1'b0;
        if (set_i)  busy_d[set_idx_i]  = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy_o = busy_q;
endmodule

// File: rtl/reg_read_stage.sv
// rtl/reg_read_stage.sv - operand read with writeback bypass, hazard stall and output register
module reg_read_stage
    import reg_read_stage_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  reg_idx_t                    in_rn,
    input  reg_idx_t                    in_rm,
    input  reg_idx_t                    in_rd,
    input  logic                        in_wr,
    input  logic [OP_W-1:0]             in_op,
    input  logic [NREG-1:0][DATA_W-1:0] rf_q,
    input  logic                        wb_valid,
    input  reg_idx_t                    wb_rd,
    input  logic [DATA_W-1:0]           wb_data,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_a,
    output logic [DATA_W-1:0]           out_b,
    output reg_idx_t                    out_rd,
    output logic                        out_wr,
    output logic [OP_W-1:0]             out_op
);
    localparam reg_idx_t ZIDX = reg_idx_t'(ZERO_REG);

    logic [NREG-1:0]   busy;
    logic              wb_hit;
    logic              haz_any;
    logic              accept;
    logic [DATA_W-1:0] a_d, b_d;
    logic              valid_q, wr_q;
    logic [DATA_W-1:0] a_q, b_q;
    reg_idx_t          rd_q;
    logic [OP_W-1:0]   op_q;

    // A writeback to the zero register is ignored for both bypass and scoreboard.
    assign wb_hit = wb_valid && (wb_rd != ZIDX);

    function automatic logic hazard(input reg_idx_t s, input logic [NREG-1:0] bsy,
                                    input logic hit, input reg_idx_t hit_idx);
        return (s != ZIDX) && bsy[s] && !(hit && hit_idx == s);
    endfunction

    function automatic logic [DATA_W-1:0] operand(input reg_idx_t s,
                                                  input logic [NREG-1:0][DATA_W-1:0] rf,
                                                  input logic hit, input reg_idx_t hit_idx,
                                                  input logic [DATA_W-1:0] hit_data);
        if (s == ZIDX)                return '0;
        else if (hit && hit_idx == s) return hit_data;
        else                          return rf[s];
    endfunction

    assign haz_any = hazard(in_rn, busy, wb_hit, wb_rd)
                  || hazard(in_rm, busy, wb_hit, wb_rd)
                  || (in_wr && hazard(in_rd, busy, wb_hit, wb_rd));

    assign in_ready = !flush && !haz_any && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    assign a_d = operand(in_rn, rf_q, wb_hit, wb_rd, wb_data);
    assign b_d = operand(in_rm, rf_q, wb_hit, wb_rd, wb_data);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            wr_q    <= 1'b0;
            op_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= in_rd;
            wr_q    <= in_wr;
            op_q    <= in_op;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    rf_scoreboard #(.NREG(NREG)) u_sb (
        .clk        (clk),
        .rst_n      (reset),
        .set_i      (accept && in_wr && (in_rd != ZIDX)),
        .set_idx_i  (in_rd),
        .clr_i      (wb_hit),
        .clr_idx_i  (wb_rd),
        .fclr_i     (flush && valid_q && wr_q && (rd_q != ZIDX)),
        .fclr_idx_i (rd_q),
        .busy_o     (busy)
    );

    assign out_valid = valid_q;
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign out_rd    = rd_q;
    assign out_wr    = wr_q;
    assign out_op    = op_q;
endmodule

// File: tb/tb_reg_read_stage.sv
// tb/tb_reg_read_stage.sv - randomized and directed checks of reg_read_stage against a behavioural model
module tb_reg_read_stage;
    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid, in_ready;
    logic [4:0]        in_rn, in_rm, in_rd;
    logic              in_wr;
    logic [10:0]       in_op;
    logic [31:0][63:0] rf_q;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [63:0]       wb_data;
    logic              flush;
    logic              out_valid, out_ready;
    logic [63:0]       out_a, out_b;
    logic [4:0]        out_rd;
    logic              out_wr;
    logic [10:0]       out_op;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] m_busy;
    logic        m_ov, m_wr;
    logic [63:0] m_a, m_b;
    logic [4:0]  m_rd;
    logic [10:0] m_op;

    always #5 clk = ~clk;

    reg_read_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd), .in_wr(in_wr), .in_op(in_op),
        .rf_q(rf_q), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_wr(out_wr), .out_op(out_op)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_haz(input logic [4:0] s);
        return (s != 5'd31) && m_busy[s] && !(wb_valid && wb_rd == s);
    endfunction

    function automatic logic m_ready();
        return !flush && !m_haz(in_rn) && !m_haz(in_rm) && !(in_wr && m_haz(in_rd))
               && (!m_ov || out_ready);
    endfunction

    function automatic logic [63:0] m_opnd(input logic [4:0] s);
        if (s == 5'd31) return 64'd0;
        if (wb_valid && wb_rd == s) return wb_data;
        return rf_q[s];
    endfunction

    task automatic m_reset();
        m_busy = '0; m_ov = 0; m_wr = 0; m_a = 0; m_b = 0; m_rd = 0; m_op = 0;
    endtask

    task automatic check_cycle();
        chk("in_ready", in_ready, m_ready());
        chk("out_valid", out_valid, m_ov);
        chk("busy", dut.busy, m_busy);
        if (m_ov) begin
            chk("out_a", out_a, m_a);
            chk("out_b", out_b, m_b);
            chk("out_rd", out_rd, m_rd);
            chk("out_wr", out_wr, m_wr);
            chk("out_op", out_op, m_op);
        end
    endtask

    task automatic model_update();
        logic        acc;
        logic [31:0] nb;
        acc = in_valid && m_ready();
        nb  = m_busy;
        if (wb_valid && wb_rd != 5'd31) nb[wb_rd] = 1'b0;
        if (flush && m_ov && m_wr && m_rd != 5'd31) nb[m_rd] = 1'b0;
        if (acc && in_wr && in_rd != 5'd31) nb[in_rd] = 1'b1;
        if (flush) m_ov = 1'b0;
        else if (acc) begin
            m_ov = 1'b1; m_a = m_opnd(in_rn); m_b = m_opnd(in_rm);
            m_rd = in_rd; m_wr = in_wr; m_op = in_op;
        end else if (out_ready) m_ov = 1'b0;
        m_busy = nb;
    endtask

    task automatic step();
        #2;
        check_cycle();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 0; in_rn = 0; in_rm = 0; in_rd = 0; in_wr = 0; in_op = 0;
        wb_valid = 0; wb_rd = 0; wb_data = 0; flush = 0; out_ready = 1;
    endtask

    function automatic logic [4:0] pick_idx();
        int r;
        r = $urandom_range(0, 9);
        return (r > 7) ? 5'd31 : 5'(r);
    endfunction

    initial begin
        reset = 0;
        idle();
        rf_q = '0;
        m_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst out_valid", out_valid, 0);
        chk("rst out_a", out_a, 0);
        chk("rst out_b", out_b, 0);
        chk("rst out_rd", out_rd, 0);
        chk("rst out_wr", out_wr, 0);
        chk("rst out_op", out_op, 0);
        chk("rst busy", dut.busy, 0);
        @(negedge clk);
        reset = 1;

        // basic operand read
        rf_q[3] = 64'd13; rf_q[4] = 64'd1309;
        in_valid = 1; in_rn = 3; in_rm = 4; in_op = 11'h5a5;
        step(); idle();
        chk("d33 out_a", out_a, 64'd13);
        chk("d33 out_b", out_b, 64'd1309);
        chk("d33 out_valid", out_valid, 1);
        step();

        // zero register reads as zero and never becomes busy
        rf_q[31] = 64'd5;
        in_valid = 1; in_rn = 31; in_rm = 3; in_wr = 1; in_rd = 31;
        step(); idle();
        chk("d34 out_a", out_a, 64'd0);
        chk("d34 busy", dut.busy, 0);
        step();

        // RAW stall released by writeback bypass
        in_valid = 1; in_wr = 1; in_rd = 7; in_rn = 31; in_rm = 31;
        step(); idle();
        in_valid = 1; in_rn = 7; in_rm = 31;
        repeat (2) begin #1; chk("d35 stall in_ready", in_ready, 0); step(); end
        wb_valid = 1; wb_rd = 7; wb_data = 64'd42;
        #1; chk("d35 bypass in_ready", in_ready, 1);
        step(); idle();
        chk("d35 out_a", out_a, 64'd42);
        chk("d35 out_valid", out_valid, 1);
        step();

        // downstream backpressure holds the output
        out_ready = 0; in_valid = 1; in_rn = 3; in_rm = 4; in_op = 11'd1;
        step();
        in_rn = 4; in_rm = 3; in_op = 11'd2;
        repeat (3) begin
            #1;
            chk("d36 in_ready", in_ready, 0);
            chk("d36 out_a", out_a, 64'd13);
            chk("d36 out_op", out_op, 11'd1);
            step();
        end
        out_ready = 1;
        #1; chk("d36 release in_ready", in_ready, 1);
        step(); idle();
        chk("d36 next out_a", out_a, 64'd1309);
        chk("d36 next out_op", out_op, 11'd2);
        step();

        // flush of a held writer releases its busy bit
        out_ready = 0; in_valid = 1; in_wr = 1; in_rd = 9; in_rn = 31; in_rm = 31;
        step(); idle();
        out_ready = 0; flush = 1;
        #1; chk("d37 flush in_ready", in_ready, 0);
        step();
        flush = 0; out_ready = 1;
        chk("d37 out_valid", out_valid, 0);
        chk("d37 busy9", dut.busy[9], 0);
        in_valid = 1; in_rn = 9; in_rm = 31;
        #1; chk("d37 rn9 in_ready", in_ready, 1);
        step(); idle(); step();

        // asynchronous reset in the middle of a stall
        out_ready = 0; in_valid = 1; in_wr = 1; in_rd = 7; in_rn = 31; in_rm = 31;
        step();
        in_wr = 0; in_rn = 7;
        step();
        #3; reset = 0; #1;
        chk("d38 out_valid", out_valid, 0);
        chk("d38 out_rd", out_rd, 0);
        chk("d38 out_wr", out_wr, 0);
        chk("d38 out_op", out_op, 0);
        chk("d38 busy", dut.busy, 0);
        m_reset();
        @(negedge clk);
        reset = 1; out_ready = 1;
        #1; chk("d38 rn7 in_ready", in_ready, 1);
        step(); idle(); step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 32; i++) rf_q[i] = {$urandom, $urandom};
            in_valid  = ($urandom_range(0, 3) != 0);
            in_rn     = pick_idx();
            in_rm     = pick_idx();
            in_rd     = pick_idx();
            in_wr     = $urandom_range(0, 1);
            in_op     = 11'($urandom);
            wb_valid  = ($urandom_range(0, 2) == 0);
            wb_rd     = pick_idx();
            wb_data   = {$urandom, $urandom};
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        idle();
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
